// File: rtl/irq_ctrl.sv
// Interrupt controller for the risc5 CPU: edge-detected, maskable request sources
// with fixed priority, a single registered irq line and intAck/RTI in-service tracking.
module irq_ctrl #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wait_req,
   input  logic [NUM_IRQ-1:0] src,
   input  logic               intack,
   input  logic               rti,
   output logic               irq,
   input  logic               stb,
   input  logic               wr,
   input  logic               addr,
   input  logic [31:0]        data_in,
   output logic [31:0]        data_out
);

   logic [NUM_IRQ-1:0] src_q;
   logic [NUM_IRQ-1:0] pending;
   logic [NUM_IRQ-1:0] en_mask;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] active;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] sw_clr;
   logic [NUM_IRQ-1:0] pending_next;
   logic               in_service;
   logic [3:0]         cur_num;
   logic [3:0]         sel;
   logic               sel_valid;
   logic               ack;
   logic               ret;
   logic               wr_en;
   logic               wr_clr;
   logic [15:0]        en_ext;
   logic [15:0]        pend_ext;
   logic               unused_data;

   assign rise        = src & ~src_q;
   assign active      = pending & en_mask;
   assign ack         = intack & ~wait_req;
   assign ret         = rti & ~wait_req;
   assign wr_en       = stb & wr & ~addr;
   assign wr_clr      = stb & wr & addr;
   assign unused_data = ^data_in;

   // Scan from the top down so the lowest active index is the one left in sel.
   always_comb begin
      sel       = 4'hF;
      sel_valid = 1'b0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            sel       = 4'(i);
            sel_valid = 1'b1;
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         ack_clr[i] = ack & sel_valid & (sel == 4'(i));
      end
      sw_clr       = wr_clr ? data_in[NUM_IRQ-1:0] : '0;
      // A fresh rising edge outranks any clear hitting the same bit.
      pending_next = (pending & ~(ack_clr | sw_clr)) | rise;
   end

   always_comb begin
      en_ext                 = '0;
      pend_ext               = '0;
      en_ext[NUM_IRQ-1:0]    = en_mask;
      pend_ext[NUM_IRQ-1:0]  = pending;
      data_out               = '0;
      if (stb && !wr) begin
         data_out = addr ? {in_service, 27'b0, cur_num} : {en_ext, pend_ext};
      end
   end

   // src_q tracks src even in reset so sources already high at release stay quiet.
   always_ff @(posedge clk) begin
      src_q <= src;
      if (!rst) begin
         pending    <= '0;
         en_mask    <= '0;
         in_service <= 1'b0;
         cur_num    <= 4'hF;
         irq        <= 1'b0;
      end else begin
         pending <= pending_next;
         if (wr_en) begin
            en_mask <= data_in[NUM_IRQ-1:0];
         end
         if (ack) begin
            cur_num    <= sel;
            in_service <= 1'b1;
         end else if (ret) begin
            in_service <= 1'b0;
         end
         irq <= (|active) & ~in_service & ~ack;
      end
   end

endmodule
